// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
//   key_evt_t    : one queued key event {code, press}
//   clog2_min1() : ceiling log2, never less than 1 (sizes counters and indices)
//   *_DEF        : default parameter values of the scanner
//   emit_state_t : event emitter states
package keypad_pkg;

   localparam int ROWS_DEF       = 4;
   localparam int COLS_DEF       = 4;
   localparam int SCAN_DIV_DEF   = 60000;
   localparam int DEBOUNCE_DEF   = 2;
   localparam int FIFO_DEPTH_DEF = 4;

   // Wide enough for the largest 8x8 matrix; narrower builds slice it.
   localparam int CODE_MAX_W = 6;

   typedef struct packed {
      logic [CODE_MAX_W-1:0] code;
      logic                  press;
   } key_evt_t;

   localparam int EVT_W = $bits(key_evt_t);

   typedef enum logic {
      EMIT_IDLE = 1'b0,
      EMIT_WALK = 1'b1
   } emit_state_t;

   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Small synchronous FIFO holding key events.
//   clk, rst_n : clock, async active-low reset (empties the queue)
//   push, din  : write request and data; dropped when full unless popping
//   full       : no free entry
//   pop, dout  : read request and head data (zero when empty)
//   empty      : no entry held
// A push into a full queue is accepted when a pop happens in the same cycle,
// because the head slot is freed at the same edge the tail slot is written.
module keypad_event_fifo
   import keypad_pkg::*;
#(
   parameter int WIDTH = EVT_W,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
            wptr              <= wptr + (AW+1)'(1);
         end
         if (do_pop) rptr <= rptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Row-scanned key matrix reader with per-key debounce and an event queue.
//   clk, rst_n             : system clock, async active-low reset
//   col                    : column lines, active-low
//   row                    : row drive, active-low one-hot
//   key_state              : debounced key map, bit r*COLS+c, 1 = pressed
//   key_press/key_release  : one-cycle pulses on key_state edges
//   evt_valid/evt_ready    : event stream handshake
//   evt_code/evt_press     : head event key index and direction
//   ovf, ovf_clr           : sticky event-loss flag and its clear
//
// Emitter FSM
//   state     | meaning
//   EMIT_IDLE | waiting for a row sample that changed at least one key
//   EMIT_WALK | visiting columns 0..COLS-1 of that row, one per cycle
module matrix_keypad_scanner
   import keypad_pkg::*;
#(
   parameter  int ROWS       = ROWS_DEF,
   parameter  int COLS       = COLS_DEF,
   parameter  int SCAN_DIV   = SCAN_DIV_DEF,
   parameter  int DEBOUNCE   = DEBOUNCE_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int CODE_W     = clog2_min1(ROWS*COLS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [COLS-1:0]      col,
   output logic [ROWS-1:0]      row,
   output logic [ROWS*COLS-1:0] key_state,
   output logic [ROWS*COLS-1:0] key_press,
   output logic [ROWS*COLS-1:0] key_release,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [CODE_W-1:0]    evt_code,
   output logic                 evt_press,
   output logic                 ovf,
   input  logic                 ovf_clr
);

   localparam int NK    = ROWS*COLS;
   localparam int DIV_W = clog2_min1(SCAN_DIV);
   localparam int ROW_W = clog2_min1(ROWS);
   localparam int COL_W = clog2_min1(COLS);
   localparam int DB_W  = 4;

   logic [DIV_W-1:0] slot_cnt;
   logic [ROW_W-1:0] row_idx;
   logic             slot_end;
   logic [COLS-1:0]  col_s1;
   logic [COLS-1:0]  col_s2;

   logic [DB_W-1:0]  dcnt [NK];
   logic [NK-1:0]    sel;
   logic [NK-1:0]    differ;
   logic [NK-1:0]    flip;
   logic [COLS-1:0]  row_flip;
   logic [COLS-1:0]  row_new;

   emit_state_t      state;
   emit_state_t      state_nx;
   logic [COLS-1:0]  chg;
   logic [COLS-1:0]  val;
   logic [ROW_W-1:0] emit_row;
   logic [COL_W-1:0] emit_col;
   logic             start;
   logic             push;
   key_evt_t         push_evt;

   key_evt_t         head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             unused_code_hi;

   // ---------------- scan timing ----------------
   assign slot_end = (slot_cnt == DIV_W'(SCAN_DIV-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         row_idx  <= '0;
      end else if (slot_end) begin
         slot_cnt <= '0;
         row_idx  <= (row_idx == ROW_W'(ROWS-1)) ? '0 : row_idx + ROW_W'(1);
      end else begin
         slot_cnt <= slot_cnt + DIV_W'(1);
      end
   end

   always_comb begin
      row          = '1;
      row[row_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_s1 <= '1;
         col_s2 <= '1;
      end else begin
         col_s1 <= col;
         col_s2 <= col_s1;
      end
   end

   // ---------------- debounce ----------------
   // A key flips on the sample that would bring its count to DEBOUNCE.
   always_comb begin
      sel    = '0;
      differ = '0;
      flip   = '0;
      for (int k = 0; k < NK; k++) begin
         sel[k]    = slot_end && (int'(row_idx) == k / COLS);
         differ[k] = (~col_s2[k % COLS]) != key_state[k];
         flip[k]   = sel[k] && differ[k] && (dcnt[k] == DB_W'(DEBOUNCE-1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_state   <= '0;
         key_press   <= '0;
         key_release <= '0;
         for (int k = 0; k < NK; k++) dcnt[k] <= '0;
      end else begin
         for (int k = 0; k < NK; k++) begin
            key_press[k]   <= flip[k] & ~key_state[k];
            key_release[k] <= flip[k] &  key_state[k];
            if (flip[k]) begin
               key_state[k] <= ~key_state[k];
               dcnt[k]      <= '0;
            end else if (sel[k]) begin
               dcnt[k] <= differ[k] ? dcnt[k] + DB_W'(1) : '0;
            end
         end
      end
   end

   // ---------------- event emitter ----------------
   always_comb begin
      row_flip = '0;
      for (int c = 0; c < COLS; c++) row_flip[c] = flip[int'(row_idx)*COLS + c];
   end

   assign row_new = ~col_s2;
   assign start   = slot_end && (|row_flip);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMIT_IDLE;
         chg      <= '0;
         val      <= '0;
         emit_row <= '0;
         emit_col <= '0;
      end else begin
         state <= state_nx;
         if (start) begin
            chg      <= row_flip;
            val      <= row_new;
            emit_row <= row_idx;
            emit_col <= '0;
         end else if (state == EMIT_WALK) begin
            emit_col <= emit_col + COL_W'(1);
         end
      end
   end

   always_comb begin
      state_nx       = state;
      push           = 1'b0;
      push_evt.code  = '0;
      push_evt.press = 1'b0;
      case (state)
         EMIT_IDLE: begin
            if (start) state_nx = EMIT_WALK;
         end
         EMIT_WALK: begin
            push           = chg[emit_col];
            push_evt.code  = CODE_MAX_W'(int'(emit_row)*COLS + int'(emit_col));
            push_evt.press = val[emit_col];
            if (emit_col == COL_W'(COLS-1)) state_nx = start ? EMIT_WALK : EMIT_IDLE;
         end
         default: state_nx = EMIT_IDLE;
      endcase
   end

   // ---------------- event queue ----------------
   keypad_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_evt),
      .full  (fifo_full),
      .pop   (evt_ready),
      .dout  (head),
      .empty (fifo_empty)
   );

   assign evt_valid      = !fifo_empty;
   assign evt_code       = head.code[CODE_W-1:0];
   assign evt_press      = head.press;
   assign unused_code_hi = |head.code;

   // A new loss wins over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (push && fifo_full && !(evt_ready && !fifo_empty)) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Bench for matrix_keypad_scanner: a physical key map drives the columns, and a
// frame-level reference model (debounce per sample, scheduled pushes into a
// bounded queue) predicts key_state, pulses, events and ovf every cycle.
module tb_matrix_keypad_scanner;

   localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 2, FIFO_DEPTH = 4;
   localparam int NK = ROWS*COLS;
   localparam int SLOT = SCAN_DIV;
   localparam int FRAME = SCAN_DIV*ROWS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    col;
   logic [3:0]    row;
   logic [15:0]   key_state, key_press, key_release;
   logic          evt_valid;
   logic          evt_ready = 1'b1;
   logic [3:0]    evt_code;
   logic          evt_press;
   logic          ovf;
   logic          ovf_clr = 1'b0;

   logic [15:0]   pressed = '0;
   int            n = 0;
   int            n_cmp = 0, n_err = 0;
   bit            rdy_rand = 0;

   typedef struct { int t; int code; int press; } ev_t;
   ev_t q[$];
   ev_t sch[$];
   ev_t log_q[$];
   bit  m_state [NK];
   int  m_db [NK];
   bit  m_ovf;
   int  n_press [NK];
   int  n_rel [NK];

   int          m_cnt, m_slot, m_r, m_k;
   logic [15:0] m_ep, m_er, m_ms;
   logic [3:0]  m_row;
   bit          m_pop, m_set;

   always #5 clk = ~clk;

   matrix_keypad_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .col(col), .row(row),
      .key_state(key_state), .key_press(key_press), .key_release(key_release),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_press(evt_press), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   // Physical matrix: a closed key pulls its column low while its row is driven.
   always_comb begin
      col = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (!row[r] && pressed[r*COLS+c]) col[c] = 1'b0;
   end

   always @(posedge clk) begin
      if (!rst_n) n = 0;
      else        n = n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   // Reference model, evaluated once per cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         sch.delete();
         m_ovf = 0;
         for (int k = 0; k < NK; k++) begin
            m_state[k] = 0;
            m_db[k]    = 0;
         end
      end else begin
         m_cnt  = n % SLOT;
         m_slot = (n / SLOT) % ROWS;
         m_row  = 4'hF;
         m_row[m_slot] = 1'b0;
         chk("row", row, m_row);
         chk("ovf", ovf, m_ovf);
         chk("evt_valid", evt_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("evt_code", evt_code, q[0].code);
            chk("evt_press", evt_press, q[0].press);
         end
         m_ep = '0;
         m_er = '0;
         if (m_cnt == 0 && n >= SLOT) begin
            m_r = (n / SLOT - 1) % ROWS;
            for (int c = 0; c < COLS; c++) begin
               m_k = m_r*COLS + c;
               if (pressed[m_k] != m_state[m_k]) begin
                  m_db[m_k]++;
                  if (m_db[m_k] >= DEBOUNCE) begin
                     m_state[m_k] = pressed[m_k];
                     m_db[m_k]    = 0;
                     if (pressed[m_k]) m_ep[m_k] = 1'b1;
                     else              m_er[m_k] = 1'b1;
                     sch.push_back('{n + c, m_k, int'(pressed[m_k])});
                  end
               end else begin
                  m_db[m_k] = 0;
               end
            end
            for (int k = 0; k < NK; k++) m_ms[k] = m_state[k];
            chk("key_state", key_state, m_ms);
         end
         chk("key_press", key_press, m_ep);
         chk("key_release", key_release, m_er);
         for (int k = 0; k < NK; k++) begin
            if (key_press[k])   n_press[k]++;
            if (key_release[k]) n_rel[k]++;
         end
         m_pop = (q.size() != 0) && evt_ready;
         if (m_pop) begin
            log_q.push_back('{n, int'(evt_code), int'(evt_press)});
            void'(q.pop_front());
         end
         m_set = 0;
         while (sch.size() != 0 && sch[0].t == n) begin
            if (q.size() < FIFO_DEPTH) q.push_back(sch[0]);
            else                       m_set = 1;
            void'(sch.pop_front());
         end
         if (m_set)        m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_rand) evt_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_cycles(input int k);
      repeat (k) tick();
   endtask

   // New key map takes effect at the start of a frame, so every row sample
   // of that frame sees it.
   task automatic set_keys(input logic [15:0] m);
      do tick(); while (n % FRAME != 1);
      pressed = m;
   endtask

   task automatic chk_log(input string tag, input int idx, input int code, input int press);
      if (idx < log_q.size()) begin
         chk({tag, "_code"}, log_q[idx].code, code);
         chk({tag, "_press"}, log_q[idx].press, press);
      end else begin
         chk({tag, "_present"}, log_q.size(), idx + 1);
      end
   endtask

   initial begin
      int base, n0, target;
      logic [15:0] m;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_row", row, 4'b1110);
      chk("rst_key_state", key_state, 0);
      chk("rst_key_press", key_press, 0);
      chk("rst_key_release", key_release, 0);
      chk("rst_evt_valid", evt_valid, 0);
      chk("rst_evt_code", evt_code, 0);
      chk("rst_evt_press", evt_press, 0);
      chk("rst_ovf", ovf, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      while (n < 8) tick();
      chk("row_after_8", row, 4'b1101);
      while (n < 32) tick();
      chk("row_wrap_32", row, 4'b1110);

      // single key press and release
      set_keys(16'h0040);
      wait_cycles(3*FRAME);
      chk("k6_state", key_state[6], 1);
      chk("k6_press_pulses", n_press[6], 1);
      chk("k6_evt_count", log_q.size(), 1);
      chk_log("k6_press_evt", 0, 6, 1);

      set_keys(16'h0000);
      wait_cycles(3*FRAME);
      chk("k6_released", key_state[6], 0);
      chk("k6_release_pulses", n_rel[6], 1);
      chk_log("k6_release_evt", 1, 6, 0);

      // bounce: alternating samples never settle
      base = log_q.size();
      for (int i = 0; i < 8; i++) set_keys((i % 2 == 0) ? 16'h0040 : 16'h0000);
      wait_cycles(2*FRAME);
      chk("bounce_state", key_state[6], 0);
      chk("bounce_no_evt", log_q.size(), base);
      chk("bounce_no_press", n_press[6], 1);

      // whole row at once
      base = log_q.size();
      set_keys(16'h0F00);
      wait_cycles(3*FRAME);
      chk("burst_count", log_q.size(), base + 4);
      for (int i = 0; i < 4; i++) begin
         chk_log("burst_evt", base + i, 8 + i, 1);
         if (base + i < log_q.size())
            chk("burst_consecutive", log_q[base + i].t, log_q[base].t + i);
      end
      set_keys(16'h0000);
      wait_cycles(3*FRAME);

      // random key maps with random back-pressure
      rdy_rand = 1;
      m = '0;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0) m = 16'($urandom & $urandom);
         set_keys(m);
      end
      set_keys(16'h0000);
      wait_cycles(3*FRAME);
      rdy_rand = 0;
      evt_ready = 1'b1;
      wait_cycles(FRAME);
      chk("random_drained", evt_valid, 0);
      chk("random_state_clear", key_state, 0);

      // overflow: five presses with the consumer stalled
      evt_ready = 1'b0;
      base = log_q.size();
      set_keys(16'h001F);
      wait_cycles(3*FRAME);
      chk("ovf_set", ovf, 1);
      chk("ovf_valid", evt_valid, 1);
      chk("ovf_head_code", evt_code, 0);
      chk("ovf_head_press", evt_press, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", ovf, 0);

      // push into a full queue on the same cycle as a pop
      set_keys(16'h005F);
      n0 = n;
      target = n0 - 1 + FRAME + 2*SLOT + 2;
      while (n < target) tick();
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      wait_cycles(2);
      chk("full_pushpop_ovf", ovf, 0);
      chk("full_pushpop_popped", log_q.size(), base + 1);
      chk_log("full_pushpop_head", base, 0, 1);
      evt_ready = 1'b1;
      wait_cycles(FRAME);
      chk_log("drain1", base + 1, 1, 1);
      chk_log("drain2", base + 2, 2, 1);
      chk_log("drain3", base + 3, 3, 1);
      chk_log("drain6", base + 4, 6, 1);
      chk("drain_empty", evt_valid, 0);

      // reset in the middle of an emission burst
      set_keys(16'hF000);
      n0 = n;
      while (n < n0 - 1 + 2*FRAME + 1) tick();
      rst_n   = 1'b0;
      pressed = '0;
      #1;
      chk("midrst_row", row, 4'b1110);
      chk("midrst_valid", evt_valid, 0);
      chk("midrst_state", key_state, 0);
      chk("midrst_code", evt_code, 0);
      chk("midrst_ovf", ovf, 0);
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(3*FRAME);
      chk("postrst_valid", evt_valid, 0);
      chk("postrst_state", key_state, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", n);
      $fatal(1, "time limit");
   end

endmodule
